alu_txn_driver: RTL and testbench

- Sequential initiator and checker for the combinational 4-bit ALU `device` (ports in1, in2, opcode, out).
- Accepts ALU commands over a valid/ready stream and drives them onto the device's operand and opcode inputs.
- Waits a fixed settle time, samples the device result, and compares it against an internal golden model.
- Returns result, expected value and mismatch flag over a valid/ready response stream; sits between a command source (CPU or test sequencer) and `device`.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_txn_driver_golden.sv | 22 ++
 rtl/alu_txn_driver.sv | 125 ++++++++++++
 tb/tb_alu_txn_driver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcode/state types and the ALU golden function used by
//             the transaction driver and by device-level benches.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Widest operand the golden function handles; callers zero-extend their
    // operands up to this width and truncate the result back to 2*W bits.
    localparam int c_MAX_W = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } drv_state_e;

    // Divide-by-zero result; all-ones at every truncated width.
    localparam logic [2*c_MAX_W-1:0] DIV0_RESULT = '1;

    // Reference ALU. Subtraction wraps modulo 2^(2*c_MAX_W), which stays
    // correct modulo 2^(2*W) after the caller truncates.
    function automatic logic [2*c_MAX_W-1:0] alu_golden(
        input logic [c_MAX_W-1:0] in1,
        input logic [c_MAX_W-1:0] in2,
        input alu_op_e            opcode
    );
        logic [2*c_MAX_W-1:0] a;
        logic [2*c_MAX_W-1:0] b;
        logic [2*c_MAX_W-1:0] r;
        a = {{c_MAX_W{1'b0}}, in1};
        b = {{c_MAX_W{1'b0}}, in2};
        case (opcode)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            OP_DIV:  r = (b == '0) ? DIV0_RESULT : (a / b);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_txn_driver_golden.sv
`default_nettype none
// ============================================================================
//  Module   : alu_golden_model
//  Purpose  : Combinational wrapper around alu_golden for a W-bit ALU
//             (W up to 16) producing a 2*W-bit expected result.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_golden_model
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0]   in1,
    input  logic [W-1:0]   in2,
    input  logic [1:0]     opcode,
    output logic [2*W-1:0] golden
);

    assign golden = (2*W)'(alu_golden(c_MAX_W'(in1), c_MAX_W'(in2), alu_op_e'(opcode)));

endmodule : alu_golden_model
`default_nettype wire

// File: rtl/alu_txn_driver.sv
`default_nettype none
// ============================================================================
//  Module   : alu_txn_driver
//  Purpose  : Takes ALU commands on a valid/ready stream, drives them onto a
//             combinational ALU device, samples its result after a fixed
//             settle time, checks it against a golden model and returns the
//             outcome on a valid/ready response stream.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_txn_driver
    import alu_pkg::*;
#(
    parameter int W      = 4,
    parameter int SETTLE = 2,    // 1..15
    parameter int CW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    // command stream
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [W-1:0]    cmd_in1,
    input  logic [W-1:0]    cmd_in2,
    input  logic [1:0]      cmd_opcode,
    // device interface
    output logic [W-1:0]    dut_in1,
    output logic [W-1:0]    dut_in2,
    output logic [1:0]      dut_opcode,
    input  logic [2*W-1:0]  dut_out,
    // response stream
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*W-1:0]  rsp_result,
    output logic [2*W-1:0]  rsp_expected,
    output logic            rsp_mismatch,
    // status
    output logic [CW-1:0]   txn_count,
    output logic [CW-1:0]   err_count,
    output logic            busy
);

    localparam int              c_SW          = 4;
    localparam logic [c_SW-1:0] c_SETTLE_LOAD = c_SW'(SETTLE - 1);

    drv_state_e         r_state;
    logic [c_SW-1:0]    r_settle;
    logic [2*W-1:0]     w_golden;

    // Expected value is computed from the live command so it can be
    // captured on the same edge the command is accepted.
    alu_golden_model #(
        .W      (W)
    ) u_golden (
        .in1    (cmd_in1),
        .in2    (cmd_in2),
        .opcode (cmd_opcode),
        .golden (w_golden)
    );

    // Transaction FSM: accept command, wait for settle, capture, hand off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_settle     <= '0;
            cmd_ready    <= 1'b1;
            dut_in1      <= '0;
            dut_in2      <= '0;
            dut_opcode   <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_expected <= '0;
            rsp_mismatch <= 1'b0;
            txn_count    <= '0;
            err_count    <= '0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        dut_in1      <= cmd_in1;
                        dut_in2      <= cmd_in2;
                        dut_opcode   <= cmd_opcode;
                        rsp_expected <= w_golden;
                        r_settle     <= c_SETTLE_LOAD;
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        r_state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_settle == '0) begin
                        rsp_result   <= dut_out;
                        rsp_mismatch <= (dut_out != rsp_expected);
                        rsp_valid    <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_settle <= r_settle - c_SW'(1);
                    end
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (txn_count != '1) begin
                            txn_count <= txn_count + CW'(1);
                        end
                        if (rsp_mismatch && (err_count != '1)) begin
                            err_count <= err_count + CW'(1);
                        end
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule : alu_txn_driver
`default_nettype wire

// File: tb/tb_alu_txn_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_txn_driver
//  Purpose  : Directed self-checking bench for alu_txn_driver with a small
//             behavioural 4-bit ALU device and a result-corruption hook.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_txn_driver;

    localparam int W      = 4;
    localparam int SETTLE = 2;
    localparam int CW     = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [W-1:0]   cmd_in1;
    logic [W-1:0]   cmd_in2;
    logic [1:0]     cmd_opcode;
    logic [W-1:0]   dut_in1;
    logic [W-1:0]   dut_in2;
    logic [1:0]     dut_opcode;
    logic [2*W-1:0] dut_out;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*W-1:0] rsp_result;
    logic [2*W-1:0] rsp_expected;
    logic           rsp_mismatch;
    logic [CW-1:0]  txn_count;
    logic [CW-1:0]  err_count;
    logic           busy;

    logic           force_zero;
    logic [2*W-1:0] dev_out;

    int checks   = 0;
    int failures = 0;
    int accepts  = 0;
    bit ok;
    int cyc;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    alu_txn_driver #(
        .W            (W),
        .SETTLE       (SETTLE),
        .CW           (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_in1      (cmd_in1),
        .cmd_in2      (cmd_in2),
        .cmd_opcode   (cmd_opcode),
        .dut_in1      (dut_in1),
        .dut_in2      (dut_in2),
        .dut_opcode   (dut_opcode),
        .dut_out      (dut_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_expected (rsp_expected),
        .rsp_mismatch (rsp_mismatch),
        .txn_count    (txn_count),
        .err_count    (err_count),
        .busy         (busy)
    );

    // Behavioural 4-bit ALU device the driver talks to.
    always_comb begin
        dev_out = 8'h00;
        case (dut_opcode)
            2'b00: dev_out = {4'h0, dut_in1} + {4'h0, dut_in2};
            2'b01: dev_out = {4'h0, dut_in1} - {4'h0, dut_in2};
            2'b10: dev_out = {4'h0, dut_in1} * {4'h0, dut_in2};
            2'b11: dev_out = (dut_in2 == 4'h0) ? 8'hFF : ({4'h0, dut_in1} / {4'h0, dut_in2});
            default: dev_out = 8'h00;
        endcase
    end

    assign dut_out = force_zero ? 8'h00 : dev_out;

    // Count command handshakes as seen on the interface.
    always @(posedge clk) begin
        if (!rst && cmd_valid && cmd_ready) accepts <= accepts + 1;
    end

    // Present a command and hold it until one accepting edge has passed.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, output bit acc);
        int n;
        @(negedge clk);
        cmd_in1    = a;
        cmd_in2    = b;
        cmd_opcode = op;
        cmd_valid  = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = cmd_ready;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Count falling edges until rsp_valid is seen (bounded).
    task automatic wait_rsp(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!rsp_valid && c < 50);
    endtask

    // One response handshake, issued from a falling edge.
    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; force_zero = 1'b0;
        cmd_in1 = '0; cmd_in2 = '0; cmd_opcode = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if ({rsp_valid, busy, rsp_mismatch} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {rsp_valid, busy, rsp_mismatch}); end
        checks++; if ({dut_in1, dut_in2, dut_opcode} !== 10'h0) begin failures++; $display("FAIL reset_dut: got %h expected 0", {dut_in1, dut_in2, dut_opcode}); end
        checks++; if ({rsp_result, rsp_expected} !== 16'h0) begin failures++; $display("FAIL reset_rsp: got %h expected 0", {rsp_result, rsp_expected}); end
        checks++; if ({txn_count, err_count} !== 32'h0) begin failures++; $display("FAIL reset_counts: got %h expected 0", {txn_count, err_count}); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        issue(4'd4, 4'd3, 2'b00, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL add_accept: got %b expected 1", ok); end
        checks++; if ({dut_in1, dut_in2, dut_opcode} !== {4'd4, 4'd3, 2'b00}) begin failures++; $display("FAIL add_dut_drive: got %h expected %h", {dut_in1, dut_in2, dut_opcode}, {4'd4, 4'd3, 2'b00}); end
        wait_rsp(cyc);
        // First sampled negedge follows the accept edge, so SETTLE edges later is SETTLE+1.
        checks++; if (cyc !== SETTLE + 1) begin failures++; $display("FAIL add_latency: got %0d expected %0d", cyc, SETTLE + 1); end
        checks++; if ({rsp_result, rsp_expected, rsp_mismatch} !== {8'd7, 8'd7, 1'b0}) begin failures++; $display("FAIL add_rsp: got %h/%h/%b expected 07/07/0", rsp_result, rsp_expected, rsp_mismatch); end
        checks++; if ({cmd_ready, busy} !== 2'b01) begin failures++; $display("FAIL add_busy: got %b expected 01", {cmd_ready, busy}); end
        handshake();
        @(negedge clk);
        checks++; if (txn_count !== 16'd1 || err_count !== 16'd0) begin failures++; $display("FAIL add_counts: got %0d/%0d expected 1/0", txn_count, err_count); end
        checks++; if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin failures++; $display("FAIL add_idle: got %b expected 100", {cmd_ready, rsp_valid, busy}); end
    endtask

    task automatic test_sub();
        // rsp_ready while nothing is pending must not count anything.
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (txn_count !== 16'd1) begin failures++; $display("FAIL idle_rsp_ready: got %0d expected 1", txn_count); end
        issue(4'd5, 4'd3, 2'b01, ok);
        wait_rsp(cyc);
        checks++; if (!rsp_valid || rsp_result !== 8'd2 || rsp_expected !== 8'd2 || rsp_mismatch !== 1'b0) begin failures++; $display("FAIL sub_5_3: got %h/%h/%b expected 02/02/0", rsp_result, rsp_expected, rsp_mismatch); end
        handshake();
        issue(4'd2, 4'd3, 2'b01, ok);
        wait_rsp(cyc);
        checks++; if (!rsp_valid || rsp_result !== 8'hFF || rsp_expected !== 8'hFF || rsp_mismatch !== 1'b0) begin failures++; $display("FAIL sub_wrap: got %h/%h/%b expected ff/ff/0", rsp_result, rsp_expected, rsp_mismatch); end
        handshake();
        @(negedge clk);
        checks++; if (txn_count !== 16'd3) begin failures++; $display("FAIL sub_count: got %0d expected 3", txn_count); end
    endtask

    task automatic test_mul_div_backpressure();
        issue(4'd2, 4'd3, 2'b10, ok);
        wait_rsp(cyc);
        // A competing command while busy must be ignored.
        cmd_in1 = 4'd9; cmd_in2 = 4'd9; cmd_opcode = 2'b00; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (!rsp_valid || rsp_result !== 8'd6 || rsp_expected !== 8'd6 || cmd_ready !== 1'b0 || dut_in1 !== 4'd2) begin
                failures++;
                $display("FAIL mul_hold[%0d]: got v=%b res=%h exp=%h rdy=%b in1=%h expected v=1 res=06 exp=06 rdy=0 in1=2", i, rsp_valid, rsp_result, rsp_expected, cmd_ready, dut_in1);
            end
        end
        cmd_valid = 1'b0;
        handshake();
        issue(4'd6, 4'd3, 2'b11, ok);
        wait_rsp(cyc);
        checks++; if (rsp_result !== 8'd2 || rsp_expected !== 8'd2 || rsp_mismatch !== 1'b0) begin failures++; $display("FAIL div_6_3: got %h/%h/%b expected 02/02/0", rsp_result, rsp_expected, rsp_mismatch); end
        handshake();
        issue(4'd6, 4'd0, 2'b11, ok);
        wait_rsp(cyc);
        checks++; if (rsp_result !== 8'hFF || rsp_expected !== 8'hFF || rsp_mismatch !== 1'b0) begin failures++; $display("FAIL div_zero: got %h/%h/%b expected ff/ff/0", rsp_result, rsp_expected, rsp_mismatch); end
        handshake();
        @(negedge clk);
        checks++; if (txn_count !== 16'd6 || err_count !== 16'd0) begin failures++; $display("FAIL muldiv_counts: got %0d/%0d expected 6/0", txn_count, err_count); end
    endtask

    task automatic test_mismatch();
        force_zero = 1'b1;
        issue(4'd4, 4'd3, 2'b00, ok);
        wait_rsp(cyc);
        checks++; if (!rsp_valid || rsp_result !== 8'h00 || rsp_expected !== 8'd7 || rsp_mismatch !== 1'b1) begin failures++; $display("FAIL mismatch_rsp: got %h/%h/%b expected 00/07/1", rsp_result, rsp_expected, rsp_mismatch); end
        handshake();
        force_zero = 1'b0;
        @(negedge clk);
        checks++; if (err_count !== 16'd1 || txn_count !== 16'd7) begin failures++; $display("FAIL mismatch_counts: got %0d/%0d expected 1/7", err_count, txn_count); end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        issue(4'd9, 4'd2, 2'b10, ok);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin failures++; $display("FAIL midreset_flags: got %b expected 001", {rsp_valid, busy, cmd_ready}); end
        checks++; if ({txn_count, err_count} !== 32'h0) begin failures++; $display("FAIL midreset_counts: got %h expected 0", {txn_count, err_count}); end
        checks++; if ({dut_in1, dut_in2, dut_opcode} !== 10'h0) begin failures++; $display("FAIL midreset_dut: got %h expected 0", {dut_in1, dut_in2, dut_opcode}); end
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_rsp: got %b expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        int a0;
        a0 = accepts;
        @(negedge clk);
        cmd_in1 = 4'd3; cmd_in2 = 4'd2; cmd_opcode = 2'b10;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        repeat (4 * (SETTLE + 2)) @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        checks++; if (accepts - a0 !== 4) begin failures++; $display("FAIL b2b_accepts: got %0d expected 4", accepts - a0); end
        checks++; if (txn_count !== 16'd4 || err_count !== 16'd0) begin failures++; $display("FAIL b2b_counts: got %0d/%0d expected 4/0", txn_count, err_count); end
        repeat (3) @(negedge clk);
        checks++; if ({busy, cmd_ready, rsp_valid} !== 3'b010 || dut_in1 !== 4'd3) begin failures++; $display("FAIL b2b_idle: got %b in1=%h expected 010 in1=3", {busy, cmd_ready, rsp_valid}, dut_in1); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul_div_backpressure();
        test_mismatch();
        test_reset_mid_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_txn_driver
`default_nettype wire
